// File: rtl/tdm_demux_8ch.sv
// Eight-channel TDM demultiplexer: collects a frame of samples into working
// registers and presents each completed frame on a double-buffered output bank.
module tdm_demux_8ch #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   input  logic             frame_ack,
   output logic [WIDTH-1:0] ya,
   output logic [WIDTH-1:0] yb,
   output logic [WIDTH-1:0] yc,
   output logic [WIDTH-1:0] yd,
   output logic [WIDTH-1:0] ye,
   output logic [WIDTH-1:0] yf,
   output logic [WIDTH-1:0] yg,
   output logic [WIDTH-1:0] yh,
   output logic             frame_valid,
   output logic             overrun,
   output logic [2:0]       ch_idx
);

   localparam int unsigned NCH = 8;
   localparam int unsigned IW  = 3;

   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] work_q [NCH];
   logic [WIDTH-1:0] work_d [NCH];
   logic [WIDTH-1:0] out_q  [NCH];
   logic [WIDTH-1:0] out_d  [NCH];
   logic             fv_q, fv_d;
   logic             ov_q, ov_d;
   logic [IW-1:0]    wr_idx_c;
   logic             complete_c;

   // Next-state: sample capture, pointer advance, frame hand-off and flags
   always_comb begin
      ptr_d      = ptr_q;
      work_d     = work_q;
      out_d      = out_q;
      fv_d       = fv_q;
      ov_d       = ov_q;
      wr_idx_c   = sync ? '0 : ptr_q;
      complete_c = din_valid && !sync && (ptr_q == IW'(NCH - 1));

      if (din_valid) begin
         work_d[wr_idx_c] = din;
         ptr_d            = sync ? IW'(1) : ptr_q + IW'(1);
      end else if (sync) begin
         ptr_d = '0;
      end

      // Channel 7 comes straight from din so the frame is visible one cycle later
      if (complete_c) begin
         for (int unsigned i = 0; i < NCH - 1; i++) begin
            out_d[i] = work_q[i];
         end
         out_d[NCH-1] = din;
      end

      if (complete_c)     fv_d = 1'b1;
      else if (frame_ack) fv_d = 1'b0;

      if (complete_c && fv_q && !frame_ack) ov_d = 1'b1;
      else if (frame_ack)                   ov_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         fv_q  <= 1'b0;
         ov_q  <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            work_q[i] <= '0;
            out_q[i]  <= '0;
         end
      end else begin
         ptr_q  <= ptr_d;
         fv_q   <= fv_d;
         ov_q   <= ov_d;
         work_q <= work_d;
         out_q  <= out_d;
      end
   end

   assign ya          = out_q[0];
   assign yb          = out_q[1];
   assign yc          = out_q[2];
   assign yd          = out_q[3];
   assign ye          = out_q[4];
   assign yf          = out_q[5];
   assign yg          = out_q[6];
   assign yh          = out_q[7];
   assign frame_valid = fv_q;
   assign overrun     = ov_q;
   assign ch_idx      = ptr_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch with WIDTH=4; outputs are compared as one
// packed word {ya..yh} against hand-computed frames.
module tb_tdm_demux_8ch;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din;
   logic       din_valid, sync, frame_ack;
   logic [3:0] ya, yb, yc, yd, ye, yf, yg, yh;
   logic       frame_valid, overrun;
   logic [2:0] ch_idx;

   int errors = 0;
   int checks = 0;

   tdm_demux_8ch #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .frame_ack(frame_ack),
      .ya(ya), .yb(yb), .yc(yc), .yd(yd), .ye(ye), .yf(yf), .yg(yg), .yh(yh),
      .frame_valid(frame_valid), .overrun(overrun), .ch_idx(ch_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] outs();
      return {ya, yb, yc, yd, ye, yf, yg, yh};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive on the falling edge, return 1 time unit after the rising edge
   task automatic beat(input logic [3:0] d, input logic v, input logic s, input logic a);
      @(negedge clk);
      din = d; din_valid = v; sync = s; frame_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [31:0] vals, input logic ack_last);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] v;
         v = vals >> (4 * (7 - i));
         beat(v[3:0], 1'b1, i == 0, ack_last && (i == 7));
      end
   endtask

   initial begin
      rst = 1'b1; din = 4'hF; din_valid = 1'b1; sync = 1'b1; frame_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ch_idx", 32'(ch_idx), 32'd0);
      check("rst_fv", 32'(frame_valid), 32'd0);
      check("rst_ov", 32'(overrun), 32'd0);
      check("rst_outs", outs(), 32'h0);
      @(negedge clk);
      rst = 1'b0; din_valid = 1'b0; sync = 1'b0;

      // First frame 1..8, sync on first beat
      beat(4'h1, 1'b1, 1'b1, 1'b0);
      for (int i = 2; i <= 7; i++) beat(4'(i), 1'b1, 1'b0, 1'b0);
      check("pre_complete_fv", 32'(frame_valid), 32'd0);
      check("pre_complete_outs", outs(), 32'h0);
      check("pre_complete_idx", 32'(ch_idx), 32'd7);
      beat(4'h8, 1'b1, 1'b0, 1'b0);
      check("f1_outs", outs(), 32'h12345678);
      check("f1_fv", 32'(frame_valid), 32'd1);
      check("f1_idx", 32'(ch_idx), 32'd0);
      check("f1_ov", 32'(overrun), 32'd0);

      // Acknowledge, then a partial frame
      beat(4'h0, 1'b0, 1'b0, 1'b1);
      check("ack_fv", 32'(frame_valid), 32'd0);
      beat(4'h9, 1'b1, 1'b0, 1'b0);
      beat(4'hA, 1'b1, 1'b0, 1'b0);
      beat(4'hB, 1'b1, 1'b0, 1'b0);
      check("partial_fv", 32'(frame_valid), 32'd0);
      check("partial_outs", outs(), 32'h12345678);
      check("partial_idx", 32'(ch_idx), 32'd3);

      // Idle cycle holds the pointer
      beat(4'h5, 1'b0, 1'b0, 1'b0);
      check("idle_idx", 32'(ch_idx), 32'd3);

      // Mid-frame resync discards beats 1..5
      beat(4'h1, 1'b1, 1'b1, 1'b0);
      for (int i = 2; i <= 5; i++) beat(4'(i), 1'b1, 1'b0, 1'b0);
      check("resync_pre_idx", 32'(ch_idx), 32'd5);
      beat(4'hA, 1'b1, 1'b1, 1'b0);
      check("resync_idx", 32'(ch_idx), 32'd1);
      check("resync_fv", 32'(frame_valid), 32'd0);
      for (int i = 0; i < 7; i++) beat(4'(4'hB + 4'(i)), 1'b1, 1'b0, 1'b0);
      check("resync_outs", outs(), 32'hABCDEF01);
      check("resync_fv2", 32'(frame_valid), 32'd1);
      beat(4'h0, 1'b0, 1'b0, 1'b1);
      check("resync_ack_fv", 32'(frame_valid), 32'd0);

      // Sync without a sample resets the pointer only
      beat(4'h3, 1'b1, 1'b0, 1'b0);
      beat(4'h4, 1'b1, 1'b0, 1'b0);
      beat(4'h7, 1'b0, 1'b1, 1'b0);
      check("sync_novalid_idx", 32'(ch_idx), 32'd0);
      check("sync_novalid_outs", outs(), 32'hABCDEF01);

      // Two frames without ack: overrun
      frame(32'h12345678, 1'b0);
      check("ovr_f1_ov", 32'(overrun), 32'd0);
      frame(32'h87654321, 1'b0);
      check("ovr_outs", outs(), 32'h87654321);
      check("ovr_fv", 32'(frame_valid), 32'd1);
      check("ovr_ov", 32'(overrun), 32'd1);
      beat(4'h0, 1'b0, 1'b0, 1'b1);
      check("ovr_ack_fv", 32'(frame_valid), 32'd0);
      check("ovr_ack_ov", 32'(overrun), 32'd0);

      // Completion with ack in the same cycle
      frame(32'hFEDCBA98, 1'b0);
      check("sameack_pre_fv", 32'(frame_valid), 32'd1);
      frame(32'h2468ACE0, 1'b1);
      check("sameack_outs", outs(), 32'h2468ACE0);
      check("sameack_fv", 32'(frame_valid), 32'd1);
      check("sameack_ov", 32'(overrun), 32'd0);

      // Asynchronous reset between edges after 4 beats
      beat(4'h1, 1'b1, 1'b1, 1'b0);
      for (int i = 2; i <= 4; i++) beat(4'(i), 1'b1, 1'b0, 1'b0);
      check("arst_pre_idx", 32'(ch_idx), 32'd4);
      #1 rst = 1'b1;
      #1;
      check("arst_idx", 32'(ch_idx), 32'd0);
      check("arst_fv", 32'(frame_valid), 32'd0);
      check("arst_ov", 32'(overrun), 32'd0);
      check("arst_outs", outs(), 32'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) beat(4'(4'h9 + 4'(i)), 1'b1, 1'b0, 1'b0);
      check("post_arst_outs", outs(), 32'h9ABCDEF0);
      check("post_arst_fv", 32'(frame_valid), 32'd1);
      check("post_arst_idx", 32'(ch_idx), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux_8ch.md
TDM_DEMUX_8CH -- requirements
Module: tdm_demux_8ch

Interface
REQ-001 SHALL have parameter WIDTH, default 4, sample width of every data port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port din  input  WIDTH  time-division-multiplexed sample stream.
REQ-005 SHALL have port din_valid  input  1  din carries a sample this cycle.
REQ-006 SHALL have port sync  input  1  start-of-frame marker.
REQ-007 SHALL have port frame_ack  input  1  consumer has taken the presented frame.
REQ-008 SHALL have ports ya, yb, yc, yd, ye, yf, yg, yh  output  WIDTH each  channel 0..7 of the last completed frame.
REQ-009 SHALL have port frame_valid  output  1  ya..yh hold an unacknowledged complete frame.
REQ-010 SHALL have port overrun  output  1  sticky: a frame was overwritten before acknowledgement.
REQ-011 SHALL have port ch_idx  output  3  channel the next accepted sample will be written to.

Function
REQ-012 SHALL hold eight WIDTH-bit working registers (ch0..ch7) plus eight WIDTH-bit output registers driving ya..yh (double buffer).
REQ-013 SHALL accept a sample on any rising edge with din_valid=1; no back-pressure; sample always accepted.
REQ-014 Without sync: accepted sample SHALL be written to working register ch_idx; ch_idx SHALL increment by 1, wrapping 7 -> 0.
REQ-015 sync=1 with din_valid=1: sample SHALL be written to ch0 regardless of ch_idx; ch_idx SHALL become 1.
REQ-016 sync=1 with din_valid=0: ch_idx SHALL become 0; no register written.
REQ-017 sync mid-frame SHALL discard the partial frame silently: no frame_valid; working registers not rewritten keep stale values.
REQ-018 din_valid=0 and sync=0: ch_idx and all registers SHALL hold.
REQ-019 Frame completion = accepted sample written to channel 7 (ch_idx=7, sync=0).
REQ-020 On the completion edge, output registers SHALL load working ch0..ch6 and the current din as channel 7; ya..yh visible the cycle after the ch7 sample is presented.
REQ-021 Outputs ya..yh SHALL change only on a completion edge or reset.
REQ-022 frame_valid SHALL set on a completion edge; clear on an edge with frame_ack=1 and no completion.
REQ-023 Completion with frame_ack=1 in the same cycle: frame_valid SHALL stay 1; overrun SHALL not set.
REQ-024 Completion while frame_valid=1 and frame_ack=0: outputs SHALL take the new frame, frame_valid stays 1, overrun SHALL set.
REQ-025 overrun SHALL clear on any edge with frame_ack=1, unless a REQ-024 condition occurs the same edge (set wins).
REQ-026 frame_ack with frame_valid=0 SHALL have no effect other than clearing overrun.
REQ-027 ch_idx SHALL be driven directly from the pointer register.

Reset
REQ-028 rst=1 SHALL immediately, without clk, force ch_idx=0, frame_valid=0, overrun=0, ya..yh=0, working registers=0.
REQ-029 rst asserted mid-frame SHALL abandon the frame; the first sample after release goes to ch0.
REQ-030 While rst=1, inputs SHALL be ignored.

Verification
REQ-031 Reset then 8 valid beats din=1..8, first with sync -> after 8th edge ya..yh=1..8, frame_valid=1, ch_idx=0, overrun=0.
REQ-032 From REQ-031, frame_ack=1 one cycle, then 3 beats 9,10,11 -> frame_valid=0, ya..yh still 1..8, ch_idx=3.
REQ-033 Beats 1..5, then sync with din=0xA, then 7 beats 0xB..0x1 -> one frame only, ya=0xA..yh=0x1; beats 1..5 never appear.
REQ-034 Two full frames, no ack -> overrun=1, frame_valid=1, ya..yh = second frame; frame_ack=1 -> both clear next edge.
REQ-035 8th beat of a frame presented with frame_ack=1 while frame_valid=1 -> frame_valid stays 1, overrun stays 0, new data on outputs.
REQ-036 rst pulsed between clock edges after 4 beats -> ch_idx=0 and all outputs 0 before next edge; next beat lands in ch0.
